// File: rtl/spi_adc_pkg.sv
// Shared types and constants for the SPI ADC capture block.
// hi_byte() builds the marked high byte written to the FIFO.
package spi_adc_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    SHIFT   = 3'd2,
    HOLD    = 3'd3,
    PUSH_HI = 3'd4,
    PUSH_LO = 3'd5
  } adc_state_t;

  localparam logic [3:0] HI_MARK  = 4'b1000;
  localparam int         ADC_BITS = 12;

  function automatic logic [7:0] hi_byte(input logic [ADC_BITS-1:0] s);
    return {HI_MARK, s[11:8]};
  endfunction

endpackage

// File: rtl/spi_adc_capture_tick.sv
// Free-running sample timer: counts 0..PERIOD-1 while enabled and
// flags the last count with a one-cycle tick.
module tick_gen
  import spi_adc_pkg::*;
#(
  parameter int PERIOD = 200
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  output logic tick_o
);

  localparam int            CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q;

  // Period counter, held at zero while disabled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {CW{1'b0}};
    end else if (!enable_i || (cnt_q == LAST)) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_q + CW'(1'b1);
    end
  end

  assign tick_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/spi_adc_capture.sv
// Periodic SPI read of a 12-bit ADC; each sample is packed into a marked
// high byte and a low byte and pushed into a byte FIFO, honouring full.
module spi_adc_capture
  import spi_adc_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int LEAD_BITS   = 3,
  parameter int SAMPLE_BITS = 12,
  parameter int PERIOD      = 200
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                miso,
  output logic                sclk,
  output logic                cs_n,
  input  logic                full,
  output logic                wr,
  output logic [7:0]          w_data,
  output logic [ADC_BITS-1:0] last_sample,
  output logic [7:0]          ovf_cnt,
  output logic                busy
);

  localparam logic [7:0]  N_C       = 8'(LEAD_BITS + SAMPLE_BITS);
  localparam logic [7:0]  LEAD_C    = 8'(LEAD_BITS);
  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HOLD_LAST = 16'(2 * CLK_DIV - 1);
  localparam int          ALIGN     = ADC_BITS - SAMPLE_BITS;

  adc_state_t          state_q;
  logic [15:0]         div_q;
  logic [7:0]          rise_q;
  logic [ADC_BITS-1:0] shreg_q;
  logic [ADC_BITS-1:0] last_sample_q;
  logic [7:0]          w_data_q;
  logic [7:0]          ovf_q;
  logic [7:0]          ovf_d;
  logic [8:0]          ovf_sum_s;
  logic                cs_n_q;
  logic                sclk_q;
  logic                busy_q;
  logic                pend_q;
  logic                tick_s;
  logic                start_s;
  logic                drop_s;
  logic                late_tick_s;

  tick_gen #(.PERIOD(PERIOD)) u_tick (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .enable_i (enable),
    .tick_o   (tick_s)
  );

  // Frame start, drop and overrun detection with saturating drop count
  always_comb begin
    start_s     = (state_q == IDLE) && pend_q;
    drop_s      = (state_q == PUSH_HI) && full;
    late_tick_s = tick_s && pend_q && !start_s;
    ovf_sum_s   = {1'b0, ovf_q} + {8'd0, drop_s} + {8'd0, late_tick_s};
    ovf_d       = ovf_sum_s[8] ? 8'hFF : ovf_sum_s[7:0];
  end

  // Pending-request flag and drop counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= 1'b0;
      ovf_q  <= 8'd0;
    end else begin
      ovf_q <= ovf_d;
      if (!enable) begin
        pend_q <= 1'b0;
      end else if (tick_s) begin
        pend_q <= 1'b1;
      end else if (start_s) begin
        pend_q <= 1'b0;
      end else begin
        pend_q <= pend_q;
      end
    end
  end

  // Frame FSM: SCLK divider, shift register and byte packing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      div_q         <= 16'd0;
      rise_q        <= 8'd0;
      shreg_q       <= {ADC_BITS{1'b0}};
      last_sample_q <= {ADC_BITS{1'b0}};
      w_data_q      <= 8'd0;
      cs_n_q        <= 1'b1;
      sclk_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pend_q) begin
            state_q <= SETUP;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            div_q   <= 16'd0;
            rise_q  <= 8'd0;
            shreg_q <= {ADC_BITS{1'b0}};
          end
        end
        SETUP: begin
          if (div_q == DIV_LAST) begin
            div_q   <= 16'd0;
            state_q <= SHIFT;
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        SHIFT: begin
          if (div_q == DIV_LAST) begin
            div_q  <= 16'd0;
            sclk_q <= ~sclk_q;
            if (!sclk_q) begin
              // rising edge: lead bits are counted but not kept
              rise_q <= rise_q + 8'd1;
              if (rise_q >= LEAD_C) begin
                shreg_q <= {shreg_q[ADC_BITS-2:0], miso};
              end
            end else if (rise_q == N_C) begin
              state_q       <= HOLD;
              cs_n_q        <= 1'b1;
              last_sample_q <= shreg_q << ALIGN;
            end
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        HOLD: begin
          if (div_q == HOLD_LAST) begin
            div_q    <= 16'd0;
            state_q  <= PUSH_HI;
            w_data_q <= hi_byte(last_sample_q);
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        PUSH_HI: begin
          if (full) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            w_data_q <= 8'd0;
          end else begin
            state_q  <= PUSH_LO;
            w_data_q <= last_sample_q[7:0];
          end
        end
        PUSH_LO: begin
          if (!full) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            w_data_q <= 8'd0;
          end
        end
        default: begin
          state_q <= IDLE;
          cs_n_q  <= 1'b1;
          sclk_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Strobe is qualified by the live full flag so no write lands on a full FIFO
  assign wr          = !full && ((state_q == PUSH_HI) || (state_q == PUSH_LO));
  assign w_data      = w_data_q;
  assign sclk        = sclk_q;
  assign cs_n        = cs_n_q;
  assign last_sample = last_sample_q;
  assign ovf_cnt     = ovf_q;
  assign busy        = busy_q;

endmodule

// File: doc/spi_adc_capture.md
# spi_adc_capture

Upstream producer for the SPI ADC byte FIFO (8-bit words, `wr`/`w_data`/`full` write port). It periodically runs one SPI read frame on a single-channel 12-bit ADC (MCP3201-style frame: lead bits, then MSB-first data) and packs each sample into two FIFO bytes. It writes those bytes into the FIFO, honouring `full`. Samples that cannot be stored are dropped and counted.

## Interface
Parameters:
- `CLK_DIV`, 4: `clk` cycles per SCLK half-period; must be ≥1.
- `LEAD_BITS`, 3: rising SCLK edges discarded before the data.
- `SAMPLE_BITS`, 12: data bits per sample; must be ≤12.
- `PERIOD`, 200: `clk` cycles between sample ticks; must be ≥ frame length + 2·CLK_DIV + 4.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock; all logic on rising edge.
- `reset_n` in 1: async active-low reset.
- `enable` in 1: runs the sample timer.
- `miso` in 1: ADC data out.
- `sclk` out 1: SPI clock; idles low.
- `cs_n` out 1: ADC chip select; idles high.
- `full` in 1: FIFO full flag.
- `wr` out 1: FIFO write strobe, one cycle per byte.
- `w_data` out 8: FIFO write data.
- `last_sample` out 12: most recent captured sample.
- `ovf_cnt` out 8: saturating count of dropped samples.
- `busy` out 1: high in any state except IDLE.

## Operation
- Timer: when `enable`=1, counts 0..PERIOD-1 and produces `tick` on the cycle it equals PERIOD-1. When `enable`=0, it is held at 0 and `pend` is cleared.
- `pend`: set by `tick`, cleared when a frame starts. A tick arriving while `pend` is already set increments `ovf_cnt`.
- FSM states:
  - IDLE: if `pend`, go to SETUP and drive `cs_n`=0.
  - SETUP: wait CLK_DIV cycles, then go to SHIFT.
  - SHIFT: SCLK toggles every CLK_DIV cycles, for N=LEAD_BITS+SAMPLE_BITS full periods. `miso` is sampled in the cycle SCLK goes 0→1. The first LEAD_BITS samples are discarded; the rest shift into `shreg` MSB first. After the Nth falling edge, go to HOLD with `cs_n`=1.
  - HOLD: `cs_n` high for 2·CLK_DIV cycles; `last_sample` is updated on entry. Then go to PUSH_HI.
  - PUSH_HI: if `full`=1, drop the sample, increment `ovf_cnt`, go to IDLE. Otherwise pulse `wr` with `w_data`={1'b1,3'b000,s[11:8]} and go to PUSH_LO.
  - PUSH_LO: stall while `full`=1. Otherwise pulse `wr` with `w_data`=s[7:0] and go to IDLE.
- A sample is never split across a drop: once the high byte is written, the low byte always follows.
- `enable` falling mid-frame: the frame completes, including the push; no further frames start.
- When SAMPLE_BITS<12, the sample is left-aligned into 12 bits and the low bits are zero.
- `ovf_cnt` saturates at 255.

## Timing
- Reset values: `cs_n`=1, `sclk`=0, `wr`=0, `w_data`=0, `last_sample`=0, `ovf_cnt`=0, `busy`=0. FSM=IDLE, timer=0, `pend`=0.
- Reset asserted mid-frame takes effect immediately: `cs_n` high and `sclk` low asynchronously.
- Tick to `cs_n` low: 2 cycles (tick sets `pend`, IDLE then drives `cs_n`).
- `cs_n` low duration: CLK_DIV + 2·CLK_DIV·N cycles. At defaults this is 4 + 120 = 124.
- End of HOLD to high-byte `wr`: 1 cycle. High-byte `wr` to low-byte `wr`: 1 cycle when `full`=0.
- `wr` is never asserted while `full`=1, and is never high on two consecutive cycles for one byte.

## Structure
- Package `spi_adc_pkg`:
  - state enum `adc_state_t`: IDLE, SETUP, SHIFT, HOLD, PUSH_HI, PUSH_LO;
  - constants `HI_MARK`=4'b1000 and `ADC_BITS`=12.
- Sub-module `tick_gen`: PERIOD counter with `enable`, producing a 1-cycle `tick`.
- Top level holds the FSM, SCLK divider, shift register and packing logic.

## Test plan
- ADC model returns 0xABC with defaults, `full`=0 → exactly two writes, 0x8A then 0xBC. `last_sample`=0xABC, `cs_n` low for 124 cycles, 15 SCLK rising edges.
- `full`=1 held through PUSH_HI → no `wr`, `ovf_cnt`=1, FSM returns to IDLE. The next frame succeeds after `full` drops.
- `full` rises after the high-byte write for 10 cycles → low byte is written on the first cycle `full`=0, with no data loss.
- `full` held 1 for 3 periods → `ovf_cnt` counts 3. Then 300 forced drops → `ovf_cnt` reads 255.
- `reset_n` pulsed low mid-SHIFT → `cs_n`=1 and `sclk`=0 immediately, no `wr`, `ovf_cnt`=0. After release, a normal frame runs.
- `enable` dropped mid-frame → that sample is still written (2 bytes), then no further `cs_n` activity for 5·PERIOD cycles.
